// File: rtl/par2ser_arb.sv
// ---------------------------------------------------------------------------
// par2ser_arb
//
// Two-source arbiter in front of a par2ser serializer. Two producers offer
// DDWIDTH-bit words. One producer is granted at a time, round-robin with an
// optional burst hold. The granted word is captured into a single-entry
// buffer. The buffer is then presented to the serializer's pull-style input
// together with the index of the source that supplied it.
//
// Handshake (upstream and downstream alike): a word moves in the cycle
// where req and ack are both high at a rising clk edge. The requester holds
// req high with stable data until it sees ack. The acknowledger drives ack
// high for exactly one cycle per transfer. If req has dropped at that edge,
// the offer is withdrawn and nothing moves.
//
// Parameters
//   DDWIDTH  word width, bit 0 = MSB
//   BURST    max consecutive deliveries from one source while both request
//
// Ports
//   clk, rst              rising-edge clock, async active-high reset
//   up0_req/ack/data      producer 0 (req/data in, ack out)
//   up1_req/ack/data      producer 1 (req/data in, ack out)
//   dn_req                serializer pulls a word (its req_in)
//   dn_ack                buffered word valid on dn_data (its ack_in)
//   dn_data, dn_src       buffered word and its source index
//   busy                  buffer holds a word not yet delivered
//   dbg_state             FSM state (0 EMPTY, 1 GRANT, 2 FULL, 3 DELIVER)
//   dbg_last, dbg_run     arbitration history (last source, burst length)
// ---------------------------------------------------------------------------
module par2ser_arb #(
  parameter int DDWIDTH = 32,
  parameter int BURST   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up0_req,
  output logic               up0_ack,
  input  logic [0:DDWIDTH-1] up0_data,
  input  logic               up1_req,
  output logic               up1_ack,
  input  logic [0:DDWIDTH-1] up1_data,
  input  logic               dn_req,
  output logic               dn_ack,
  output logic [0:DDWIDTH-1] dn_data,
  output logic               dn_src,
  output logic               busy,
  output logic [1:0]         dbg_state,
  output logic               dbg_last,
  output logic [3:0]         dbg_run
);

  localparam logic [3:0] BURST_L = 4'(BURST);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_GRANT   = 2'd1,
    S_FULL    = 2'd2,
    S_DELIVER = 2'd3
  } state_t;

  state_t             state, state_n;
  logic               sel, sel_n;
  logic               last, last_n;
  logic [3:0]         run, run_n;
  logic               up0_ack_n, up1_ack_n, dn_ack_n;
  logic [0:DDWIDTH-1] dn_data_n;
  logic               dn_src_n;
  logic               busy_n;

  // Arbitration decision, only consumed in EMPTY.
  logic grant_any;
  logic grant_src;
  logic hold_last;

  // run == 0 only right after reset: no burst is in progress, so the source
  // that is not `last` (source 0) wins the very first contention.
  assign hold_last = (run != 4'd0) && (run < BURST_L);

  always_comb begin
    grant_any = up0_req | up1_req;
    grant_src = 1'b0;
    if (up0_req && up1_req) begin
      grant_src = hold_last ? last : ~last;
    end else if (up1_req) begin
      grant_src = 1'b1;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n   = state;
    sel_n     = sel;
    last_n    = last;
    run_n     = run;
    up0_ack_n = 1'b0;
    up1_ack_n = 1'b0;
    dn_ack_n  = 1'b0;
    dn_data_n = dn_data;
    dn_src_n  = dn_src;
    busy_n    = busy;

    case (state)
      S_EMPTY: begin
        if (grant_any) begin
          sel_n     = grant_src;
          up0_ack_n = ~grant_src;
          up1_ack_n = grant_src;
          state_n   = S_GRANT;
        end
      end

      S_GRANT: begin
        // ack is high this cycle. Capture only if the producer still offers
        // the word. Otherwise treat it as an abort and leave the arbitration
        // history untouched.
        if (sel ? up1_req : up0_req) begin
          dn_data_n = sel ? up1_data : up0_data;
          dn_src_n  = sel;
          busy_n    = 1'b1;
          state_n   = S_FULL;
        end else begin
          state_n   = S_EMPTY;
        end
      end

      S_FULL: begin
        if (dn_req) begin
          dn_ack_n = 1'b1;
          state_n  = S_DELIVER;
        end
      end

      S_DELIVER: begin
        if (dn_req) begin
          busy_n  = 1'b0;
          last_n  = dn_src;
          // run saturates so a long single-source stream cannot wrap it back
          // into a range that would grant extra burst slots later.
          if (dn_src == last) begin
            run_n = (run == 4'hF) ? run : run + 4'd1;
          end else begin
            run_n = 4'd1;
          end
          state_n = S_EMPTY;
        end else begin
          // Serializer withdrew its pull; keep the word and wait again.
          state_n = S_FULL;
        end
      end

      default: begin
        state_n = S_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_EMPTY;
      sel     <= 1'b0;
      last    <= 1'b1;
      run     <= 4'd0;
      up0_ack <= 1'b0;
      up1_ack <= 1'b0;
      dn_ack  <= 1'b0;
      dn_data <= '0;
      dn_src  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      sel     <= sel_n;
      last    <= last_n;
      run     <= run_n;
      up0_ack <= up0_ack_n;
      up1_ack <= up1_ack_n;
      dn_ack  <= dn_ack_n;
      dn_data <= dn_data_n;
      dn_src  <= dn_src_n;
      busy    <= busy_n;
    end
  end

  assign dbg_state = state;
  assign dbg_last  = last;
  assign dbg_run   = run;

endmodule

// File: doc/par2ser_arb.md
# par2ser_arb

Two-source arbiter feeding one `par2ser` serializer. Two upstream producers each offer a DDWIDTH-bit parallel word; the block grants one at a time (round-robin with optional burst hold), captures the word into a single-entry buffer, and delivers it to the serializer's pull-style input handshake together with a source tag. It sits directly in front of `par2ser`: its downstream port connects to the serializer's `req_in`/`ack_in`/`data_in`.

## Interface
- `DDWIDTH`, 32, word width on all data ports (bit 0 = MSB, `[0:DDWIDTH-1]`)
- `BURST`, 1, max consecutive grants to one source while it keeps requesting (1..15)

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high
- `up0_req`  in  1  source 0 has a word; held high with data stable until acked
- `up0_ack`  out  1  one-cycle grant/accept to source 0
- `up0_data`  in  DDWIDTH  source 0 word
- `up1_req`, `up1_ack`, `up1_data`: same for source 1
- `dn_req`  in  1  serializer pulls a word (serializer `req_in`)
- `dn_ack`  out  1  word valid on `dn_data` (serializer `ack_in`)
- `dn_data`  out  DDWIDTH  buffered word
- `dn_src`  out  1  source index of buffered word
- `busy`  out  1  buffer holds a word not yet delivered

## Operation
- Handshake rule (both sides): transfer completes in the cycle where req && ack are both high at a rising edge. All outputs registered.
- States: EMPTY, GRANT, FULL, DELIVER.
- EMPTY: choose source from current `upN_req` values; if none, stay. On choice: `upS_ack`<=1, `sel`<=S, go GRANT.
- GRANT: `upS_ack` high. If `upS_req` high at edge: buffer<=`upS_data`, `dn_src`<=S, `busy`<=1, `upS_ack`<=0, go FULL. If `upS_req` low (protocol abort): `upS_ack`<=0, no capture, go EMPTY, arbitration state unchanged.
- FULL: if `dn_req` high: `dn_ack`<=1, go DELIVER. Upstream acks stay 0 (single-entry buffer, no acceptance while full).
- DELIVER: `dn_ack` high, `dn_data` stable. If `dn_req` high at edge: `dn_ack`<=0, `busy`<=0, update arbitration, go EMPTY. If `dn_req` low: `dn_ack`<=0, go FULL (word retained).
- Arbitration: `last` = last delivered source (reset 1, so source 0 wins first). Only one requester: grant it. Both requesting: if `last` requesting and `run` < BURST, grant `last`; else grant the other.
- `run` counter (4 bits): on delivery from S, `run`<=`run`+1 if S==`last` else 1; `last`<=S. BURST=1 gives strict alternation under contention.
- Abort in GRANT does not touch `last`/`run`.

## Timing
- Reset values: `up0_ack`=`up1_ack`=`dn_ack`=0, `dn_data`=0, `dn_src`=0, `busy`=0, state EMPTY, `last`=1, `run`=0. Reset mid-transfer drops all acks immediately and discards the buffered word.
- Upstream latency: `upN_req` sampled high at edge t in EMPTY -> `upN_ack` high during cycle t..t+1 -> capture at edge t+1.
- Downstream latency: `dn_req` sampled high in FULL at edge u -> `dn_ack` high u..u+1 -> delivery at edge u+1.
- `dn_req` already high when capture occurs: `dn_ack` rises one edge after capture. Minimum period 4 cycles/word.
- `upN_req` arriving while FULL/DELIVER: held by producer, considered on return to EMPTY.
- `dn_data`/`dn_src` change only on capture; `busy` falls on delivery edge.

## Test plan
- Reset, single word: source 0 offers 0x12345678, `dn_req` held high -> `up0_ack` one cycle, `dn_ack` one cycle later with `dn_data`=0x12345678, `dn_src`=0; all outputs 0 during/after async reset.
- Contention, BURST=1: both sources continuously requesting (A0..A3 / B0..B3) -> delivery order A0,B0,A1,B1,...; each ack exactly one cycle.
- BURST=3 contention: -> order A0,A1,A2,B0,B1,B2,A3,...; `run` never exceeds 3.
- Backpressure: `dn_req` low for 10 cycles after capture -> `busy`=1, no upstream ack, `dn_data` stable; `dn_req` pulse dropped during DELIVER -> word retained, redelivered on next `dn_req`.
- Abort: `up1_req` drops during GRANT -> `up1_ack` falls next edge, no capture, `busy`=0, next grant honours unchanged `last`.
- Async reset asserted in DELIVER -> `dn_ack`, `busy` low immediately; after release first grant goes to source 0.
